parking_meter_display: RTL and testbench
========================================

Name: parking_meter_display

Overview:
- Consumes the 16-bit binary time-remaining value produced by the parking-meter counter and presents it on the 4-digit common-anode seven-segment display.
- Free-running sequential binary-to-BCD conversion (double-dabble), time-multiplexed digit scan, and meter blink rules: 1 Hz flash at zero, 2 s-period flash below 200, steady otherwise.
- Sits between the counter block and the board display pins.

Parameters:
- CLK_HZ, 100_000_000: SYS_CLK frequency. Sets the quarter-second blink tick (CLK_HZ/4 cycles).
- REFRESH_BITS, 18: width of the scan counter. Its top 2 bits select the active digit.
- MAX_DISP, 9999: clamp ceiling for displayed value.

Ports:
- SYS_CLK, input, 1: system clock, rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- Bin_In, input, 16: binary seconds remaining, unsigned.
- BCD_Out, output, 16: committed BCD value, 4 nibbles, thousands in [15:12].
- Conv_Done, output, 1: one-cycle pulse when BCD_Out is updated.
- An, output, 4: digit anodes, active-low, An[0] = ones digit.
- Seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- Dp, output, 1: decimal point, active-low, held 1 (off).

Behaviour:
- Clock and reset: clock SYS_CLK; reset RESET, asynchronous, active-high.
- Reset values: BCD_Out=0, Conv_Done=0, An=4'b1111, Seg=7'h7F, Dp=1. Converter state LOAD, scan counter 0, blink tick counter 0, blink phase 0.
- Converter FSM (sub-module), states LOAD, SHIFT, COMMIT; free-running, 18-cycle period.
  - LOAD (1 cycle): capture min(Bin_In, MAX_DISP) into the shift register; clear the BCD accumulator; bit counter=15.
  - SHIFT (16 cycles): for each nibble ≥5, add 3; then shift left 1 with the next binary MSB in. Decrement the bit counter; leave after count 0.
  - COMMIT (1 cycle): BCD_Out <= accumulator; Conv_Done=1 for this cycle only; go to LOAD.
  - Latency: Bin_In sampled in LOAD is visible on BCD_Out at the end of COMMIT, 18 cycles later.
  - BCD_Out changes only in COMMIT, so it never shows a partial result.
  - Bin_In changes during SHIFT are ignored until the next LOAD.
- Clamp: Bin_In > 9999 (e.g. 16'hFFFF) yields BCD_Out=16'h9999.
- Display mode, decoded from committed BCD_Out:
  - ZERO: BCD_Out==0.
  - LOW: 0 < value < 200, i.e. thousands==0, hundreds ≤1, not zero.
  - NORMAL: otherwise.
- Blink timer:
  - Tick counter counts 0..CLK_HZ/4-1 and wraps; the wrap increments a 3-bit phase counter (quarter seconds, wraps at 8 = 2 s).
  - ZERO: display on when phase[1]==0 (0.5 s on / 0.5 s off).
  - LOW: on when phase[2]==0 (1 s on / 1 s off).
  - NORMAL: always on.
  - The timer free-runs and is not reset on mode change.
- Scan:
  - Scan counter increments every cycle and wraps.
  - Digit index d = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - An = ~(1<<d) when display on, else 4'b1111.
  - Seg = decode(BCD_Out nibble d) when on, else 7'h7F.
  - Leading zeros are displayed, not blanked.
  - Nibble values 10..15 (unreachable) decode to all-off.
  - An and Seg are registered: one cycle behind the counter/data.
- Reset mid-conversion aborts; the first valid BCD_Out arrives 18 cycles after RESET deasserts.

Decomposition:
- Shared package:
  - 7-seg decode constants for 0..9 and blank.
  - Converter state encodings (LOAD, SHIFT, COMMIT).
  - Display-mode encodings (ZERO, LOW, NORMAL).
  - LOW threshold constant 200.
  - MAX_DISP default.
- One sub-module, bin2bcd_seq: LOAD/SHIFT/COMMIT FSM with Bin_In, BCD_Out, Conv_Done.
- Top level holds the blink timer, mode decode, scan counter, segment decode and output registers.

Test Plan:
- Run with CLK_HZ=16, REFRESH_BITS=4.
- Reset then Bin_In=16'd1234 -> first Conv_Done 18 cycles after RESET falls; BCD_Out=16'h1234; An cycles 1110,1101,1011,0111 every 4 cycles with Seg=4,3,2,1 patterns; steady (no blanking).
- Bin_In=16'd0 -> BCD_Out=0; An=1111 on phases 2,3,6,7; digits shown "0000" on phases 0,1,4,5 (each phase 4 cycles).
- Bin_In=16'd199 -> LOW mode: display on for phases 0-3, An=1111 for phases 4-7. Then Bin_In=16'd200 -> after next COMMIT, continuous display of "0200".
- Bin_In=16'd65535 -> BCD_Out=16'h9999, NORMAL mode; Bin_In=16'd10000 -> 16'h9999.
- Change Bin_In 2437->5 during SHIFT -> that COMMIT gives 16'h2437; the next gives 16'h0005 and LOW blinking.
- Assert RESET mid-SHIFT -> An=1111, Seg=7F, BCD_Out=0 immediately; conversion restarts from LOAD on release.

Source files
------------

// File: rtl/parking_meter_display_pkg.sv
// Shared definitions for the parking-meter display slice.
//   - converter state and display mode enums
//   - seven-segment patterns, active-low {g,f,e,d,c,b,a}
//   - LOW threshold and default display ceiling
package parking_meter_display_pkg;

    typedef enum logic [1:0] {
        CONV_LOAD,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_t;

    typedef enum logic [1:0] {
        MODE_ZERO,
        MODE_LOW,
        MODE_NORMAL
    } disp_mode_t;

    localparam int unsigned LOW_THRESH       = 200;
    localparam int unsigned MAX_DISP_DEFAULT = 9999;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Nibbles 10..15 cannot come out of the converter; they show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/parking_meter_display_if.sv
// Data bundle between the meter counter and the display block.
//   Bin_In    : binary seconds remaining (from counter)
//   BCD_Out   : committed BCD value, thousands in [15:12]
//   Conv_Done : one-cycle pulse when BCD_Out updates
//   An, Seg, Dp : active-low display pins
// slave = display block, master = counter/board side.
interface parking_meter_display_if;
    logic [15:0] Bin_In;
    logic [15:0] BCD_Out;
    logic        Conv_Done;
    logic [3:0]  An;
    logic [6:0]  Seg;
    logic        Dp;

    modport master (output Bin_In, input BCD_Out, Conv_Done, An, Seg, Dp);
    modport slave  (input Bin_In, output BCD_Out, Conv_Done, An, Seg, Dp);
endinterface

// File: rtl/parking_meter_display_bin2bcd_seq.sv
// Free-running sequential binary-to-BCD converter (double dabble).
// 18-cycle period: LOAD (1), SHIFT (16), COMMIT (1).
//   SYS_CLK, RESET : clock, async active-high reset
//   Bin_In         : binary input, clamped to MAX_DISP at LOAD
//   BCD_Out        : result, updated only in COMMIT
//   Conv_Done      : one-cycle pulse coincident with the BCD_Out update
module bin2bcd_seq
    import parking_meter_display_pkg::*;
#(
    parameter int unsigned MAX_DISP = MAX_DISP_DEFAULT
) (
    input  logic        SYS_CLK,
    input  logic        RESET,
    input  logic [15:0] Bin_In,
    output logic [15:0] BCD_Out,
    output logic        Conv_Done
);

    conv_state_t state, state_nxt;
    logic [15:0] bin_sr;
    logic [15:0] acc;
    logic [15:0] acc_adj;
    logic [15:0] bin_clamped;
    logic [3:0]  bit_cnt;

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) state <= CONV_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_LOAD:   state_nxt = CONV_SHIFT;
            CONV_SHIFT:  if (bit_cnt == 4'd0) state_nxt = CONV_COMMIT;
            CONV_COMMIT: state_nxt = CONV_LOAD;
            default:     state_nxt = CONV_LOAD;
        endcase
    end

    always_comb begin
        bin_clamped = (Bin_In > 16'(MAX_DISP)) ? 16'(MAX_DISP) : Bin_In;
    end

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        acc_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3
                                                          : acc[4*i +: 4];
        end
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            bin_sr    <= '0;
            acc       <= '0;
            bit_cnt   <= 4'd15;
            BCD_Out   <= '0;
            Conv_Done <= 1'b0;
        end else begin
            Conv_Done <= 1'b0;
            case (state)
                CONV_LOAD: begin
                    bin_sr  <= bin_clamped;
                    acc     <= '0;
                    bit_cnt <= 4'd15;
                end
                CONV_SHIFT: begin
                    acc     <= {acc_adj[14:0], bin_sr[15]};
                    bin_sr  <= {bin_sr[14:0], 1'b0};
                    bit_cnt <= bit_cnt - 4'd1;
                end
                CONV_COMMIT: begin
                    BCD_Out   <= acc;
                    Conv_Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/parking_meter_display.sv
// Parking-meter display: BCD conversion, blink timer, digit scan.
//   SYS_CLK, RESET : clock, async active-high reset
//   pm (slave)     : Bin_In in; BCD_Out, Conv_Done, An, Seg, Dp out
// Blink: ZERO flashes 0.5 s on/off, LOW (<200) 1 s on/off, NORMAL steady.
module parking_meter_display
    import parking_meter_display_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned MAX_DISP     = MAX_DISP_DEFAULT
) (
    input  logic                    SYS_CLK,
    input  logic                    RESET,
    parking_meter_display_if.slave  pm
);

    localparam int unsigned TICK_MAX = CLK_HZ / 4 - 1;
    localparam int unsigned TICK_W   = (CLK_HZ / 4 > 1) ? $clog2(CLK_HZ / 4) : 1;

    logic [15:0]             bcd_q;
    logic                    done_q;
    logic [TICK_W-1:0]       tick_cnt;
    logic [2:0]              phase;
    logic [REFRESH_BITS-1:0] scan_cnt;
    disp_mode_t              mode;
    logic                    disp_on;
    logic [1:0]              digit;
    logic [3:0]              nibble;
    logic [3:0]              an_q;
    logic [6:0]              seg_q;

    bin2bcd_seq #(.MAX_DISP(MAX_DISP)) u_conv (
        .SYS_CLK   (SYS_CLK),
        .RESET     (RESET),
        .Bin_In    (pm.Bin_In),
        .BCD_Out   (bcd_q),
        .Conv_Done (done_q)
    );

    // Quarter-second tick feeding a 3-bit phase (2 s wrap); never restarted on mode change.
    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            tick_cnt <= '0;
            phase    <= '0;
        end else if (tick_cnt == TICK_W'(TICK_MAX)) begin
            tick_cnt <= '0;
            phase    <= phase + 3'd1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_comb begin
        mode = MODE_NORMAL;
        if (bcd_q == 16'h0000)
            mode = MODE_ZERO;
        else if (bcd_q[15:12] == 4'd0 && bcd_q[11:8] < 4'(LOW_THRESH / 100))
            mode = MODE_LOW;

        case (mode)
            MODE_ZERO: disp_on = ~phase[1];
            MODE_LOW:  disp_on = ~phase[2];
            default:   disp_on = 1'b1;
        endcase

        digit  = scan_cnt[REFRESH_BITS-1 -: 2];
        nibble = bcd_q[4*digit +: 4];
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            scan_cnt <= '0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            an_q     <= disp_on ? ~(4'b0001 << digit) : '1;
            seg_q    <= disp_on ? seg_decode(nibble) : SEG_BLANK;
        end
    end

    assign pm.BCD_Out   = bcd_q;
    assign pm.Conv_Done = done_q;
    assign pm.An        = an_q;
    assign pm.Seg       = seg_q;
    assign pm.Dp        = 1'b1;

endmodule

// File: tb/tb_parking_meter_display.sv
module tb_parking_meter_display;

    logic SYS_CLK = 1'b0;
    logic RESET   = 1'b1;

    parking_meter_display_if pm();

    parking_meter_display #(
        .CLK_HZ       (16),
        .REFRESH_BITS (4),
        .MAX_DISP     (9999)
    ) dut (
        .SYS_CLK (SYS_CLK),
        .RESET   (RESET),
        .pm      (pm)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int cyc;

    // Hand-derived active-low {g,f,e,d,c,b,a} patterns for 0..9.
    int seg_tab [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
    int pw [4] = '{1, 10, 100, 1000};

    // Rising edges since RESET released.
    always @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every Conv_Done pulse is matched against the queue.
    always begin
        @(posedge SYS_CLK);
        #1;
        if (!RESET && pm.Conv_Done && exp_q.size() > 0)
            chk("bcd_out", int'(pm.BCD_Out), exp_q.pop_front());
    end

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge SYS_CLK);
            #1;
            if (pm.Conv_Done) begin
                n = i;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL conv_done_timeout actual=none required=pulse within 40 cycles");
    endtask

    // Issue a new value so that the next LOAD samples it.
    task automatic apply(input int v, input int exp_bcd);
        int n;
        wait_done(n);
        @(negedge SYS_CLK);
        pm.Bin_In = 16'(v);
        exp_q.push_back(exp_bcd);
    endtask

    task automatic check_display(input int v, input int ncyc);
        int k, d, ph, dv, exp_an, exp_seg;
        bit on;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge SYS_CLK);
            #1;
            k  = cyc;
            d  = ((k - 1) >> 2) & 3;
            ph = ((k - 1) >> 2) & 7;
            if (v == 0)       on = ((ph & 2) == 0);
            else if (v < 200) on = ((ph & 4) == 0);
            else              on = 1'b1;
            dv      = (v / pw[d]) % 10;
            exp_an  = on ? ((~(1 << d)) & 15) : 15;
            exp_seg = on ? seg_tab[dv] : 'h7F;
            chk("an",  int'(pm.An),  exp_an);
            chk("seg", int'(pm.Seg), exp_seg);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        pm.Bin_In = 16'd1234;
        RESET     = 1'b1;
        repeat (3) @(posedge SYS_CLK);
        #1;
        chk("rst_an",   int'(pm.An),        'hF);
        chk("rst_seg",  int'(pm.Seg),       'h7F);
        chk("rst_bcd",  int'(pm.BCD_Out),   0);
        chk("rst_done", int'(pm.Conv_Done), 0);
        chk("rst_dp",   int'(pm.Dp),        1);

        exp_q.push_back('h1234);
        @(negedge SYS_CLK);
        RESET = 1'b0;
        wait_done(n);
        chk("first_latency", n, 18);
        check_display(1234, 32);

        apply(0, 'h0000);
        wait_done(n);
        check_display(0, 32);

        apply(199, 'h0199);
        wait_done(n);
        check_display(199, 32);

        apply(200, 'h0200);
        wait_done(n);
        check_display(200, 32);

        apply(65535, 'h9999);
        wait_done(n);
        check_display(9999, 8);

        apply(10000, 'h9999);
        wait_done(n);

        // Change mid-SHIFT: current conversion keeps 2437, next picks up 5.
        apply(2437, 'h2437);
        repeat (5) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        pm.Bin_In = 16'd5;
        exp_q.push_back('h0005);
        wait_done(n);
        wait_done(n);
        check_display(5, 32);

        // Reset in the middle of SHIFT.
        wait_done(n);
        repeat (6) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        RESET = 1'b1;
        #1;
        chk("midrst_an",   int'(pm.An),        'hF);
        chk("midrst_seg",  int'(pm.Seg),       'h7F);
        chk("midrst_bcd",  int'(pm.BCD_Out),   0);
        chk("midrst_done", int'(pm.Conv_Done), 0);
        exp_q.push_back('h0005);
        @(negedge SYS_CLK);
        RESET = 1'b0;
        wait_done(n);
        chk("midrst_latency", n, 18);

        @(negedge SYS_CLK);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
